imc_dpram_sync: RTL

Synchronous true dual-port RAM for the IMC decoder datapath, replacing the asynchronous read/write dual-port array. Both ports can read and write on one clock, with registered reads and a defined policy for address collisions. A built-in clear engine fills the array with a programmable value after reset or on request. It sits between the decoder control FSM (port 0) and the input-feature loader (port 1).

---
 rtl/imc_ram_pkg.sv | 13 +
 rtl/imc_ram_rdport.sv | 28 ++
 rtl/imc_dpram_sync.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/imc_ram_pkg.sv
// Shared definitions for the IMC decoder dual-port RAM: read-during-write
// policy selectors and the clear-engine state encoding.
package imc_ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    CLR_S_CLEAR,
    CLR_S_IDLE
  } clr_state_t;

endpackage

// File: rtl/imc_ram_rdport.sv
// Per-port registered read stage: captures the resolved read word, zeroes
// out-of-range reads and produces the one-cycle rvalid pulse.
module imc_ram_rdport #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic                  in_range,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  // rdata only moves on an accepted read so it holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        rdata <= in_range ? rd_word : '0;
      end
    end
  end

endmodule

// File: rtl/imc_dpram_sync.sv
// Synchronous true dual-port RAM with port-0-wins write arbitration,
// selectable cross-port read-during-write result and a built-in clear engine.
module imc_dpram_sync
  import imc_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    RAM_DEPTH  = 64,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int                    RDW_MODE   = RDW_OLD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_req,
  output logic                  busy,
  input  logic                  cs_0,
  input  logic                  we_0,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic                  rvalid_0,
  input  logic                  cs_1,
  input  logic                  we_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic                  rvalid_1,
  output logic                  collision
);

  localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  clr_state_t       state, state_nxt;
  logic [IDX_W-1:0] clr_cnt, clr_cnt_nxt;

  logic             in_range_0, in_range_1;
  logic [IDX_W-1:0] idx_0, idx_1;
  logic             same_addr;
  logic             wr_0, wr_1_req, wr_1, collide;
  logic             rd_0, rd_1;
  logic [DATA_WIDTH-1:0] rd_word_0, rd_word_1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLR_S_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // init_req is only honoured from IDLE; a request during a clear is dropped.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      CLR_S_CLEAR: begin
        if (clr_cnt == IDX_W'(RAM_DEPTH - 1)) begin
          state_nxt   = CLR_S_IDLE;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      CLR_S_IDLE: begin
        if (init_req) begin
          state_nxt   = CLR_S_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLR_S_CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  assign busy = (state == CLR_S_CLEAR);

  assign in_range_0 = {1'b0, addr_0} < (ADDR_WIDTH + 1)'(RAM_DEPTH);
  assign in_range_1 = {1'b0, addr_1} < (ADDR_WIDTH + 1)'(RAM_DEPTH);
  assign idx_0      = addr_0[IDX_W-1:0];
  assign idx_1      = addr_1[IDX_W-1:0];
  assign same_addr  = (addr_0 == addr_1);

  // Port 0 owns a contested address; port 1's write is dropped and flagged.
  assign wr_0     = !busy && cs_0 && we_0 && in_range_0;
  assign wr_1_req = !busy && cs_1 && we_1 && in_range_1;
  assign collide  = wr_0 && wr_1_req && same_addr;
  assign wr_1     = wr_1_req && !collide;
  assign rd_0     = !busy && cs_0 && !we_0;
  assign rd_1     = !busy && cs_1 && !we_1;

  always_comb begin
    rd_word_0 = mem[idx_0];
    rd_word_1 = mem[idx_1];
    if (RDW_MODE == RDW_NEW) begin
      if (wr_1 && same_addr) rd_word_0 = wdata_1;
      if (wr_0 && same_addr) rd_word_1 = wdata_0;
    end
  end

  // The array itself is never reset; the clear engine initialises it.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_cnt] <= INIT_VALUE;
    end else begin
      if (wr_0) mem[idx_0] <= wdata_0;
      if (wr_1) mem[idx_1] <= wdata_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision <= 1'b0;
    end else begin
      collision <= collide;
    end
  end

  imc_ram_rdport #(.DATA_WIDTH(DATA_WIDTH)) u_rdport_0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_0),
    .in_range (in_range_0),
    .rd_word  (rd_word_0),
    .rdata    (rdata_0),
    .rvalid   (rvalid_0)
  );

  imc_ram_rdport #(.DATA_WIDTH(DATA_WIDTH)) u_rdport_1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_1),
    .in_range (in_range_1),
    .rd_word  (rd_word_1),
    .rdata    (rdata_1),
    .rvalid   (rvalid_1)
  );

endmodule
